// File: rtl/mfp_irq_ctrl.sv
// MFP68901 interrupt controller: 16 prioritised channels with enable/pending/mask/in-service
// registers, an active-low CPU request and the IACK vector handshake.
module mfp_irq_ctrl #(
    parameter int IACK_SYNC = 2
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [15:0] EVT,
    input  logic        WE,
    input  logic [3:0]  REG_SEL,
    input  logic [7:0]  DAT_I,
    output logic [7:0]  DAT_O,
    input  logic        IACK,
    output logic        IRQ_N,
    output logic [7:0]  VEC_O,
    output logic        VEC_VALID
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GRANT = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    logic [15:0] ier_reg, ipr_reg, isr_reg, imr_reg;
    logic [15:0] ipr_next, isr_next;
    logic [15:0] ipr_clr, isr_clr, isr_set;
    logic [7:0]  vr_reg;
    logic [7:0]  dat_o_reg, dat_o_next;
    logic        irq_n_reg;
    logic [7:0]  vec_o_reg;
    logic        vec_valid_reg;
    logic [1:0]  state_reg;
    logic [IACK_SYNC-1:0] iack_sync_reg;
    logic        iack_prev_reg;

    logic [15:0] elig;
    logic [3:0]  top_e, top_isr;
    logic        request, iack_s, iack_rise, grant_hit;

    function automatic logic [3:0] top_idx(input logic [15:0] x);
        top_idx = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (x[i]) top_idx = 4'(i);
        end
    endfunction

    assign elig    = ipr_reg & imr_reg;
    assign top_e   = top_idx(elig);
    assign top_isr = top_idx(isr_reg);
    // With S set, a channel only interrupts above the highest channel still in service.
    assign request = (elig != 16'h0000) &&
                     (!vr_reg[3] || (isr_reg == 16'h0000) || (top_e > top_isr));

    assign iack_s    = iack_sync_reg[IACK_SYNC-1];
    assign iack_rise = iack_s & ~iack_prev_reg;
    assign grant_hit = (state_reg == ST_GRANT) && request;

    always_comb begin
        ipr_clr = 16'h0000;
        isr_clr = 16'h0000;
        isr_set = 16'h0000;
        if (WE) begin
            case (REG_SEL)
                4'd0: ipr_clr[15:8] = ~DAT_I;
                4'd1: ipr_clr[7:0]  = ~DAT_I;
                4'd2: ipr_clr[15:8] = ~DAT_I;
                4'd3: ipr_clr[7:0]  = ~DAT_I;
                4'd4: isr_clr[15:8] = ~DAT_I;
                4'd5: isr_clr[7:0]  = ~DAT_I;
                4'd8: if (!DAT_I[3]) isr_clr = 16'hFFFF;
                default: ;
            endcase
        end
        if (grant_hit) begin
            ipr_clr[top_e] = 1'b1;
            if (vr_reg[3]) isr_set[top_e] = 1'b1;
        end
    end

    // A new event always beats a same-cycle clear of its pending bit.
    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_chan
            assign ipr_next[gi] = (ipr_reg[gi] & ~ipr_clr[gi]) | (EVT[gi] & ier_reg[gi]);
            assign isr_next[gi] = (isr_reg[gi] & ~isr_clr[gi]) | isr_set[gi];
        end
    endgenerate

    always_comb begin
        dat_o_next = 8'h00;
        case (REG_SEL)
            4'd0: dat_o_next = ier_reg[15:8];
            4'd1: dat_o_next = ier_reg[7:0];
            4'd2: dat_o_next = ipr_reg[15:8];
            4'd3: dat_o_next = ipr_reg[7:0];
            4'd4: dat_o_next = isr_reg[15:8];
            4'd5: dat_o_next = isr_reg[7:0];
            4'd6: dat_o_next = imr_reg[15:8];
            4'd7: dat_o_next = imr_reg[7:0];
            4'd8: dat_o_next = vr_reg;
            default: dat_o_next = 8'h00;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ier_reg   <= 16'h0000;
            ipr_reg   <= 16'h0000;
            isr_reg   <= 16'h0000;
            imr_reg   <= 16'h0000;
            vr_reg    <= 8'h00;
            dat_o_reg <= 8'h00;
            irq_n_reg <= 1'b1;
        end else begin
            ipr_reg   <= ipr_next;
            isr_reg   <= isr_next;
            dat_o_reg <= dat_o_next;
            irq_n_reg <= ~request;
            if (WE) begin
                case (REG_SEL)
                    4'd0: ier_reg[15:8] <= DAT_I;
                    4'd1: ier_reg[7:0]  <= DAT_I;
                    4'd6: imr_reg[15:8] <= DAT_I;
                    4'd7: imr_reg[7:0]  <= DAT_I;
                    4'd8: vr_reg        <= DAT_I;
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            iack_sync_reg <= '0;
            iack_prev_reg <= 1'b0;
        end else begin
            iack_sync_reg[0] <= IACK;
            for (int i = 1; i < IACK_SYNC; i++) begin
                iack_sync_reg[i] <= iack_sync_reg[i-1];
            end
            iack_prev_reg <= iack_s;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_reg     <= ST_IDLE;
            vec_o_reg     <= 8'h00;
            vec_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: if (iack_rise) state_reg <= ST_GRANT;
                ST_GRANT: begin
                    // A spurious acknowledge leaves the vector invalid until release.
                    if (request) begin
                        vec_o_reg     <= {vr_reg[7:4], top_e};
                        vec_valid_reg <= 1'b1;
                    end
                    state_reg <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (!iack_s) begin
                        vec_valid_reg <= 1'b0;
                        state_reg     <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign DAT_O     = dat_o_reg;
    assign IRQ_N     = irq_n_reg;
    assign VEC_O     = vec_o_reg;
    assign VEC_VALID = vec_valid_reg;

endmodule

// File: tb/tb_mfp_irq_ctrl.sv
// Directed bench for mfp_irq_ctrl: pending, priority, in-service, auto-EOI, collisions,
// spurious acknowledge and reset during the hold phase.
module tb_mfp_irq_ctrl;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic [15:0] EVT = 16'h0000;
    logic        WE = 1'b0;
    logic [3:0]  REG_SEL = 4'd0;
    logic [7:0]  DAT_I = 8'h00;
    logic [7:0]  DAT_O;
    logic        IACK = 1'b0;
    logic        IRQ_N;
    logic [7:0]  VEC_O;
    logic        VEC_VALID;

    int total = 0;
    int bad = 0;

    mfp_irq_ctrl #(.IACK_SYNC(2)) dut (
        .CLK(CLK), .RST_N(RST_N), .EVT(EVT), .WE(WE), .REG_SEL(REG_SEL),
        .DAT_I(DAT_I), .DAT_O(DAT_O), .IACK(IACK), .IRQ_N(IRQ_N),
        .VEC_O(VEC_O), .VEC_VALID(VEC_VALID)
    );

    always #5 CLK = ~CLK;

    task automatic wr(input logic [3:0] sel, input logic [7:0] d);
        @(negedge CLK);
        WE = 1'b1; REG_SEL = sel; DAT_I = d;
        @(negedge CLK);
        WE = 1'b0; DAT_I = 8'h00;
    endtask

    task automatic rd(input logic [3:0] sel, output logic [7:0] d);
        @(negedge CLK);
        REG_SEL = sel;
        @(negedge CLK);
        d = DAT_O;
    endtask

    task automatic pulse(input logic [15:0] v);
        @(negedge CLK);
        EVT = v;
        @(negedge CLK);
        EVT = 16'h0000;
    endtask

    task automatic wait_valid(input logic lvl, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            if (VEC_VALID === lvl) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        RST_N = 1'b0;
        repeat (3) @(negedge CLK);
        total++; if (IRQ_N !== 1'b1) begin bad++; $display("FAIL rst_irq_n got=%b exp=1", IRQ_N); end else $display("pass rst_irq_n");
        total++; if (VEC_VALID !== 1'b0) begin bad++; $display("FAIL rst_vec_valid got=%b exp=0", VEC_VALID); end else $display("pass rst_vec_valid");
        total++; if (VEC_O !== 8'h00) begin bad++; $display("FAIL rst_vec_o got=%h exp=00", VEC_O); end else $display("pass rst_vec_o");
        total++; if (DAT_O !== 8'h00) begin bad++; $display("FAIL rst_dat_o got=%h exp=00", DAT_O); end else $display("pass rst_dat_o");
        RST_N = 1'b1;
    endtask

    task automatic test_enable_pend;
        logic [7:0] d;
        wr(4'd1, 8'h20);
        wr(4'd7, 8'h20);
        @(negedge CLK);
        EVT = 16'h0020; REG_SEL = 4'd3;
        @(negedge CLK);
        EVT = 16'h0000;
        total++; if (DAT_O !== 8'h00) begin bad++; $display("FAIL iprb_t1 got=%h exp=00", DAT_O); end else $display("pass iprb_t1");
        total++; if (IRQ_N !== 1'b1) begin bad++; $display("FAIL irq_t1 got=%b exp=1", IRQ_N); end else $display("pass irq_t1");
        @(negedge CLK);
        total++; if (DAT_O !== 8'h20) begin bad++; $display("FAIL iprb_t2 got=%h exp=20", DAT_O); end else $display("pass iprb_t2");
        total++; if (IRQ_N !== 1'b0) begin bad++; $display("FAIL irq_t2 got=%b exp=0", IRQ_N); end else $display("pass irq_t2");
        pulse(16'h0040);
        rd(4'd3, d);
        total++; if (d !== 8'h20) begin bad++; $display("FAIL iprb_disabled got=%h exp=20", d); end else $display("pass iprb_disabled");
    endtask

    task automatic test_priority_vector;
        logic [7:0] d;
        logic ok;
        wr(4'd0, 8'h20);
        wr(4'd6, 8'h20);
        wr(4'd8, 8'h48);
        pulse(16'h2000);
        rd(4'd2, d);
        total++; if (d !== 8'h20) begin bad++; $display("FAIL ipra_set got=%h exp=20", d); end else $display("pass ipra_set");
        @(negedge CLK); IACK = 1'b1;
        wait_valid(1'b1, ok);
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL ack_valid got=timeout exp=valid"); end else $display("pass ack_valid");
        total++; if (VEC_O !== 8'h4D) begin bad++; $display("FAIL ack_vec got=%h exp=4d", VEC_O); end else $display("pass ack_vec");
        rd(4'd4, d);
        total++; if (d !== 8'h20) begin bad++; $display("FAIL ack_isra got=%h exp=20", d); end else $display("pass ack_isra");
        rd(4'd2, d);
        total++; if (d !== 8'h00) begin bad++; $display("FAIL ack_ipra got=%h exp=00", d); end else $display("pass ack_ipra");
        rd(4'd3, d);
        total++; if (d !== 8'h20) begin bad++; $display("FAIL ack_iprb got=%h exp=20", d); end else $display("pass ack_iprb");
        total++; if (VEC_VALID !== 1'b1) begin bad++; $display("FAIL hold_valid got=%b exp=1", VEC_VALID); end else $display("pass hold_valid");
        @(negedge CLK); IACK = 1'b0;
        wait_valid(1'b0, ok);
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL ack_release got=timeout exp=invalid"); end else $display("pass ack_release");
    endtask

    task automatic test_in_service;
        logic [7:0] d;
        total++; if (IRQ_N !== 1'b1) begin bad++; $display("FAIL isr_block got=%b exp=1", IRQ_N); end else $display("pass isr_block");
        wr(4'd4, 8'hDF);
        total++; if (IRQ_N !== 1'b1) begin bad++; $display("FAIL isr_clr_t1 got=%b exp=1", IRQ_N); end else $display("pass isr_clr_t1");
        @(negedge CLK);
        total++; if (IRQ_N !== 1'b0) begin bad++; $display("FAIL isr_clr_t2 got=%b exp=0", IRQ_N); end else $display("pass isr_clr_t2");
        rd(4'd4, d);
        total++; if (d !== 8'h00) begin bad++; $display("FAIL isra_cleared got=%h exp=00", d); end else $display("pass isra_cleared");
        wr(4'd3, 8'hDF);
        repeat (2) @(negedge CLK);
        total++; if (IRQ_N !== 1'b1) begin bad++; $display("FAIL ipr_clear_irq got=%b exp=1", IRQ_N); end else $display("pass ipr_clear_irq");
    endtask

    task automatic test_auto_eoi;
        logic [7:0] d;
        logic ok;
        wr(4'd8, 8'h40);
        wr(4'd0, 8'h01);
        wr(4'd6, 8'h01);
        pulse(16'h0100);
        @(negedge CLK); IACK = 1'b1;
        wait_valid(1'b1, ok);
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL eoi_valid got=timeout exp=valid"); end else $display("pass eoi_valid");
        total++; if (VEC_O !== 8'h48) begin bad++; $display("FAIL eoi_vec got=%h exp=48", VEC_O); end else $display("pass eoi_vec");
        rd(4'd4, d);
        total++; if (d !== 8'h00) begin bad++; $display("FAIL eoi_isra got=%h exp=00", d); end else $display("pass eoi_isra");
        rd(4'd5, d);
        total++; if (d !== 8'h00) begin bad++; $display("FAIL eoi_isrb got=%h exp=00", d); end else $display("pass eoi_isrb");
        @(negedge CLK); IACK = 1'b0;
        wait_valid(1'b0, ok);
        wr(4'd8, 8'h48);
        pulse(16'h0100);
        @(negedge CLK); IACK = 1'b1;
        wait_valid(1'b1, ok);
        rd(4'd4, d);
        total++; if (d !== 8'h01) begin bad++; $display("FAIL s1_isra got=%h exp=01", d); end else $display("pass s1_isra");
        @(negedge CLK); IACK = 1'b0;
        wait_valid(1'b0, ok);
        wr(4'd8, 8'h40);
        rd(4'd4, d);
        total++; if (d !== 8'h00) begin bad++; $display("FAIL vr_s_clear got=%h exp=00", d); end else $display("pass vr_s_clear");
        rd(4'd8, d);
        total++; if (d !== 8'h40) begin bad++; $display("FAIL vr_read got=%h exp=40", d); end else $display("pass vr_read");
    endtask

    task automatic test_collision;
        logic [7:0] d;
        logic ok;
        wr(4'd0, 8'h20);
        wr(4'd6, 8'h20);
        pulse(16'h2000);
        @(negedge CLK);
        WE = 1'b1; REG_SEL = 4'd2; DAT_I = 8'hDF; EVT = 16'h2000;
        @(negedge CLK);
        WE = 1'b0; DAT_I = 8'h00; EVT = 16'h0000;
        rd(4'd2, d);
        total++; if (d !== 8'h20) begin bad++; $display("FAIL wr_collision got=%h exp=20", d); end else $display("pass wr_collision");
        // IACK at N0 is synchronised by N2 and edge-detected by N3, so GRANT occupies the cycle after N3.
        @(negedge CLK); IACK = 1'b1;
        repeat (3) @(negedge CLK);
        total++; if (VEC_VALID !== 1'b0) begin bad++; $display("FAIL pre_grant got=%b exp=0", VEC_VALID); end else $display("pass pre_grant");
        EVT = 16'h2000;
        @(negedge CLK);
        EVT = 16'h0000;
        total++; if (VEC_VALID !== 1'b1) begin bad++; $display("FAIL grant_valid got=%b exp=1", VEC_VALID); end else $display("pass grant_valid");
        total++; if (VEC_O !== 8'h4D) begin bad++; $display("FAIL grant_vec got=%h exp=4d", VEC_O); end else $display("pass grant_vec");
        rd(4'd2, d);
        total++; if (d !== 8'h20) begin bad++; $display("FAIL grant_collision got=%h exp=20", d); end else $display("pass grant_collision");
        @(negedge CLK); IACK = 1'b0;
        wait_valid(1'b0, ok);
        wr(4'd2, 8'hDF);
        rd(4'd2, d);
        total++; if (d !== 8'h00) begin bad++; $display("FAIL ipra_clear got=%h exp=00", d); end else $display("pass ipra_clear");
        rd(4'd12, d);
        total++; if (d !== 8'h00) begin bad++; $display("FAIL unmapped got=%h exp=00", d); end else $display("pass unmapped");
    endtask

    task automatic test_spurious_reset;
        logic [7:0] d;
        logic ok;
        logic quiet;
        wr(4'd6, 8'h00);
        wr(4'd7, 8'h00);
        pulse(16'h2000);
        repeat (2) @(negedge CLK);
        total++; if (IRQ_N !== 1'b1) begin bad++; $display("FAIL masked_irq got=%b exp=1", IRQ_N); end else $display("pass masked_irq");
        IACK = 1'b1;
        quiet = 1'b1;
        repeat (8) begin
            @(negedge CLK);
            if (VEC_VALID !== 1'b0) quiet = 1'b0;
        end
        total++; if (quiet !== 1'b1) begin bad++; $display("FAIL spurious got=valid exp=invalid"); end else $display("pass spurious");
        IACK = 1'b0;
        repeat (4) @(negedge CLK);
        wr(4'd6, 8'h20);
        @(negedge CLK); IACK = 1'b1;
        wait_valid(1'b1, ok);
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL post_spurious got=timeout exp=valid"); end else $display("pass post_spurious");
        total++; if (VEC_O !== 8'h4D) begin bad++; $display("FAIL post_spurious_vec got=%h exp=4d", VEC_O); end else $display("pass post_spurious_vec");
        wr(4'd8, 8'h48);
        REG_SEL = 4'd8;
        repeat (2) @(negedge CLK);
        RST_N = 1'b0;
        #1;
        total++; if (VEC_VALID !== 1'b0) begin bad++; $display("FAIL hold_rst_valid got=%b exp=0", VEC_VALID); end else $display("pass hold_rst_valid");
        total++; if (IRQ_N !== 1'b1) begin bad++; $display("FAIL hold_rst_irq got=%b exp=1", IRQ_N); end else $display("pass hold_rst_irq");
        total++; if (VEC_O !== 8'h00) begin bad++; $display("FAIL hold_rst_vec got=%h exp=00", VEC_O); end else $display("pass hold_rst_vec");
        total++; if (DAT_O !== 8'h00) begin bad++; $display("FAIL hold_rst_dat got=%h exp=00", DAT_O); end else $display("pass hold_rst_dat");
        IACK = 1'b0;
        @(negedge CLK);
        RST_N = 1'b1;
        rd(4'd0, d);
        total++; if (d !== 8'h00) begin bad++; $display("FAIL rst_iera got=%h exp=00", d); end else $display("pass rst_iera");
        rd(4'd6, d);
        total++; if (d !== 8'h00) begin bad++; $display("FAIL rst_imra got=%h exp=00", d); end else $display("pass rst_imra");
        rd(4'd8, d);
        total++; if (d !== 8'h00) begin bad++; $display("FAIL rst_vr got=%h exp=00", d); end else $display("pass rst_vr");
        total++; if (VEC_VALID !== 1'b0) begin bad++; $display("FAIL rst_no_ack got=%b exp=0", VEC_VALID); end else $display("pass rst_no_ack");
    endtask

    initial begin
        test_reset();
        test_enable_pend();
        test_priority_vector();
        test_in_service();
        test_auto_eoi();
        test_collision();
        test_spurious_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mfp_irq_ctrl.md
Name: mfp_irq_ctrl

Overview:
- 16-channel interrupt controller for the MFP68901 block.
- Collects single-cycle event pulses from the four timer instances (T_O_PULSE) and the other MFP sources.
- Gates each source by enable and mask registers and arbitrates by fixed priority.
- Drives the active-low CPU interrupt request, and runs the interrupt-acknowledge handshake that returns the 8-bit vector and optionally marks the channel in-service.

Parameters:
- IACK_SYNC, 2, number of flip-flop stages synchronising IACK into the CLK domain (minimum 1).

Ports:
- CLK  in  1  system clock
- RST_N  in  1  asynchronous active-low reset
- EVT  in  16  event pulses, one CLK cycle wide; bit 15 is highest priority
- WE  in  1  register write strobe, one cycle
- REG_SEL  in  4  register select: 0 IERA(15:8), 1 IERB(7:0), 2 IPRA, 3 IPRB, 4 ISRA, 5 ISRB, 6 IMRA, 7 IMRB, 8 VR; 9-15 unmapped
- DAT_I  in  8  write data
- DAT_O  out  8  registered read data
- IACK  in  1  CPU interrupt-acknowledge, level, asynchronous
- IRQ_N  out  1  interrupt request, active low, registered
- VEC_O  out  8  vector for the acknowledged channel
- VEC_VALID  out  1  VEC_O valid; held while the acknowledge is active

Behaviour:
- Reset (RST_N low, asynchronous):
  - IER, IPR, ISR, IMR, VR all 0x00.
  - IRQ_N=1, VEC_O=0x00, VEC_VALID=0, DAT_O=0x00.
  - FSM in IDLE; IACK synchroniser cleared.
  - Reset taken mid-acknowledge aborts it immediately.
- Pending:
  - EVT[i]=1 with IER[i]=1 sets IPR[i] on the next edge. EVT with IER[i]=0 is discarded.
  - Writing IER with bit i=0 clears IPR[i] in the same edge.
- Register writes:
  - IPR and ISR writes are clear-only: a 0 bit clears, a 1 bit leaves unchanged.
  - IER, IMR and VR are written directly.
  - Writing VR with VR[3]=0 (S bit, auto-EOI) clears all ISR bits.
- Simultaneous events:
  - EVT[i] in the same cycle as a write or acknowledge that clears IPR[i]: set wins, IPR[i]=1 afterwards.
- Reads:
  - DAT_O = selected register, one cycle after REG_SEL is presented.
  - Unmapped selects read 0x00.
  - VR reads back all 8 bits.
- Eligibility:
  - E = IPR & IMR. Let top(x) be the highest set bit index.
  - S=0: request when E != 0.
  - S=1: request when E != 0 and (ISR == 0 or top(E) > top(ISR)).
  - IRQ_N = ~request, registered. An EVT at cycle t gives IPR at t+1 and IRQ_N low at t+2.
- Acknowledge FSM (IACK sampled through IACK_SYNC stages; only the rising edge of the synchronised signal starts a cycle):
  - IDLE: on synchronised IACK rise, go to GRANT.
  - GRANT (1 cycle):
    - If request is true, capture n = top(E). Clear IPR[n] unless EVT[n] is set this cycle. If S=1, set ISR[n]. Set VEC_O = {VR[7:4], n[3:0]} and VEC_VALID=1, then go to HOLD.
    - If no request (spurious), keep VEC_VALID=0 and VEC_O unchanged, then go to HOLD.
  - HOLD: VEC_O/VEC_VALID held. When synchronised IACK is low, drop VEC_VALID next edge and return to IDLE.
  - New IACK rises during GRANT/HOLD are ignored.
- IRQ_N keeps tracking eligibility in every state, so a higher-priority arrival during HOLD may reassert it.
- Register writes are accepted in all states. A mask or enable change between IACK rise and GRANT affects the arbitration result.

Test Plan:
- Enable/pend: IERB=0x20, IMRB=0x20, pulse EVT[5] -> IPRB=0x20 at t+1, IRQ_N=0 at t+2. EVT[6] with IERB bit 6 clear -> IPRB unchanged.
- Priority/vector: VR=0x48 (S=1), IPR bits 13 and 5 set and unmasked, raise IACK -> VEC_O=0x4D, VEC_VALID=1, ISRA=0x20, IPRA=0x00, IPRB=0x20. Release IACK -> VEC_VALID=0.
- In-service blocking: continuing the above, IRQ_N stays 1 (ch5 < ch13 in service). Write ISRA=0xDF -> IRQ_N=0 two cycles later.
- Auto-EOI: VR=0x40, acknowledge ch8 -> VEC_O=0x48, ISR stays 0x0000. Writing VR S 1->0 with ISR=0x0100 clears ISR.
- Collision: EVT[13] in the same cycle as an IPRA write of 0xDF -> IPRA bit 5 remains 1. Same-cycle GRANT on ch13 with EVT[13] -> IPRA bit 5 remains 1.
- Spurious and reset: IACK with IMR=0 -> VEC_VALID stays 0, FSM returns to IDLE after IACK low. RST_N low during HOLD -> VEC_VALID=0, IRQ_N=1, all registers 0x00 immediately.
